// File: rtl/draw_sequencer.sv
// draw_sequencer: walks the per-frame object list and hands each active index to the
// display datapath, waiting for its done. Optional erase sweep: define DRAW_SEQ_ERASE_EN.
module draw_sequencer #(
  parameter int unsigned NUM_OBJ        = 5,
  parameter int unsigned CS_W           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [NUM_OBJ-1:0] obj_active,
  input  logic               obj_done,
  output logic [CS_W-1:0]    control_signal,
  output logic               obj_start,
  output logic               plot,
  output logic               erase,
  output logic               busy,
  output logic               frame_done,
  output logic               timeout_err,
  output logic               overrun_err
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [CS_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_OBJ-1:0] snap_q, snap_d;
  logic               tmo_q, tmo_d;
  logic               ovr_q, ovr_d;
  logic [CS_W:0]      pick;
  logic [CS_W:0]      first_new, first_snap, next_snap;
`ifdef DRAW_SEQ_ERASE_EN
  logic [NUM_OBJ-1:0] prev_q, prev_d;
  logic               erase_q, erase_d;
  logic [CS_W:0]      next_prev;
`endif

  // {found, index} of the lowest set bit of mask, either anywhere or strictly above cur
  function automatic logic [CS_W:0] scan(input logic [NUM_OBJ-1:0] mask,
                                         input logic [CS_W-1:0]    cur,
                                         input logic               from_start);
    logic [CS_W:0] r;
    r = '0;
    for (int unsigned i = NUM_OBJ; i > 0; i--) begin
      if (mask[i-1] && (from_start || (CS_W'(i-1) > cur)))
        r = {1'b1, CS_W'(i-1)};
    end
    return r;
  endfunction

  assign first_new  = scan(obj_active, '0, 1'b1);
  assign first_snap = scan(snap_q, '0, 1'b1);
  assign next_snap  = scan(snap_q, idx_q, 1'b0);
`ifdef DRAW_SEQ_ERASE_EN
  assign next_prev  = scan(prev_q, idx_q, 1'b0);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    tmo_d   = tmo_q;
    ovr_d   = ovr_q;
    pick    = '0;
`ifdef DRAW_SEQ_ERASE_EN
    prev_d  = prev_q;
    erase_d = erase_q;
`endif

    if (frame_tick && (state_q != S_IDLE))
      ovr_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          snap_d = obj_active;
`ifdef DRAW_SEQ_ERASE_EN
          // the outgoing snapshot becomes the erase list for this pass
          prev_d = snap_q;
          if (first_snap[CS_W]) begin
            pick    = first_snap;
            erase_d = 1'b1;
          end else begin
            pick    = first_new;
            erase_d = 1'b0;
          end
`else
          pick = first_new;
`endif
          if (pick[CS_W]) begin
            idx_d   = pick[CS_W-1:0];
            state_d = S_ARM;
          end else begin
            state_d = S_FINISH;
          end
        end
      end
      S_ARM: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (obj_done || (cnt_q == CNT_LAST)) begin
          if (!obj_done)
            tmo_d = 1'b1;
`ifdef DRAW_SEQ_ERASE_EN
          if (erase_q && next_prev[CS_W]) begin
            pick = next_prev;
          end else if (erase_q) begin
            pick    = first_snap;
            erase_d = 1'b0;
          end else begin
            pick = next_snap;
          end
`else
          pick = next_snap;
`endif
          if (pick[CS_W]) begin
            idx_d   = pick[CS_W-1:0];
            state_d = S_ARM;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      snap_q  <= '0;
      tmo_q   <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DRAW_SEQ_ERASE_EN
      prev_q  <= '0;
      erase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      tmo_q   <= tmo_d;
      ovr_q   <= ovr_d;
`ifdef DRAW_SEQ_ERASE_EN
      prev_q  <= prev_d;
      erase_q <= erase_d;
`endif
    end
  end

  assign control_signal = idx_q;
  assign obj_start      = (state_q == S_ARM);
  assign plot           = (state_q == S_ARM) || (state_q == S_WAIT_DONE);
  assign busy           = plot;
  assign frame_done     = (state_q == S_FINISH);
  assign timeout_err    = tmo_q;
  assign overrun_err    = ovr_q;
`ifdef DRAW_SEQ_ERASE_EN
  assign erase          = erase_q && plot;
`else
  assign erase          = 1'b0;
`endif

endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: queue-based behavioural model of the draw pass, cycle compare,
// directed literal scenarios, then randomized ticks/masks/done timing.
module tb_draw_sequencer;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [4:0] obj_active = '0;
  logic       obj_done = 1'b0;
  logic [3:0] control_signal;
  logic       obj_start, plot, erase, busy, frame_done, timeout_err, overrun_err;

  draw_sequencer #(.NUM_OBJ(5), .CS_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .obj_active(obj_active),
    .obj_done(obj_done), .control_signal(control_signal), .obj_start(obj_start),
    .plot(plot), .erase(erase), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .overrun_err(overrun_err));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- behavioural model: a pass is a queue of {erase,index} jobs
  int m_ph = 0;        // 0 idle, 1 start cycle, 2 waiting, 3 pass end
  int m_q[$];
  int m_idx = 0, m_er = 0, m_wait = 0, m_snap = 0, m_prev = 0;
  bit m_tmo = 0, m_ovr = 0;

  function automatic void m_next();
    int job;
    if (m_q.size() == 0) m_ph = 3;
    else begin
      job = m_q.pop_front();
      m_idx = job % 16;
      m_er = job / 16;
      m_ph = 1;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = 0; m_q.delete(); m_idx = 0; m_er = 0; m_wait = 0;
      m_snap = 0; m_prev = 0; m_tmo = 0; m_ovr = 0;
    end else begin
      if (m_ph != 0 && frame_tick) m_ovr = 1;
      case (m_ph)
        0: if (frame_tick) begin
          m_q.delete();
`ifdef DRAW_SEQ_ERASE_EN
          m_prev = m_snap;
          for (int i = 0; i < 5; i++) if (m_prev[i]) m_q.push_back(16 + i);
`endif
          m_snap = int'(obj_active);
          for (int i = 0; i < 5; i++) if (m_snap[i]) m_q.push_back(i);
          m_next();
        end
        1: begin m_ph = 2; m_wait = 0; end
        2: begin
          m_wait++;
          if (obj_done) m_next();
          else if (m_wait == TO) begin m_tmo = 1; m_next(); end
        end
        default: m_ph = 0;
      endcase
    end
  end

  // ---------------- compare + event logs
  int st_cs[$], st_cyc[$], st_er[$], fd_cyc[$];
  int plot_cnt = 0;
  logic [10:0] exp_v, act_v;

  always @(negedge clk) begin
    exp_v = {4'(m_idx), m_ph == 1, (m_ph == 1 || m_ph == 2), (m_er == 1) && (m_ph == 1 || m_ph == 2),
             (m_ph == 1 || m_ph == 2), m_ph == 3, m_tmo, m_ovr};
    act_v = {control_signal, obj_start, plot, erase, busy, frame_done, timeout_err, overrun_err};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL outputs cyc=%0d actual=%h required=%h", cyc, act_v, exp_v);
    end
    if (obj_start) begin
      st_cs.push_back(int'(control_signal)); st_cyc.push_back(cyc); st_er.push_back(int'(erase));
    end
    if (frame_done) fd_cyc.push_back(cyc);
    if (plot) plot_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    st_cs.delete(); st_cyc.delete(); st_er.delete(); fd_cyc.delete(); plot_cnt = 0;
  endtask

  // ---------------- stimulus: datapath responder folded into the per-cycle driver
  int  resp_mode = 0;   // 0 pulse after resp_dly, 1 held high, 2 never
  int  resp_dly = 3;
  int  left = 0;
  bit  rnd_en = 0;

  task automatic cycle(input bit tk);
    int r;
    @(posedge clk); #2;
    frame_tick = tk;
    if (rnd_en) obj_active = 5'($urandom);
    if (obj_start) begin
      if (rnd_en) begin
        r = $urandom_range(0, 15);
        resp_mode = (r == 0) ? 2 : (r < 3) ? 1 : 0;
        resp_dly = $urandom_range(1, 10);
      end
      left = resp_dly;
      obj_done = (resp_mode == 1) || (rnd_en && $urandom_range(0, 1) == 1);
    end else if (left > 0) begin
      left--;
      obj_done = (resp_mode == 1) || (resp_mode == 0 && left == 0);
    end else begin
      obj_done = (resp_mode == 1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1; frame_tick = 1'b0; obj_done = 1'b0; left = 0;
    #1;
    chk("reset_outputs", int'({control_signal, obj_start, plot, erase, busy, frame_done,
                               timeout_err, overrun_err}), 0);
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  int t;

  initial begin
    @(posedge clk); #2;
    chk("reset_outputs_init", int'({control_signal, obj_start, plot, erase, busy, frame_done,
                                    timeout_err, overrun_err}), 0);
    reset = 1'b0;

    // 1: mask 10011, done 3 cycles after each start
    clear_logs(); resp_mode = 0; resp_dly = 3; obj_active = 5'b10011;
    cycle(1); t = cyc;
    repeat (16) cycle(0);
    chk("t1_nstart", st_cs.size(), 3);
    chk("t1_cs0", qget(st_cs, 0), 0);
    chk("t1_cs1", qget(st_cs, 1), 1);
    chk("t1_cs2", qget(st_cs, 2), 4);
    chk("t1_start0", qget(st_cyc, 0), t + 1);
    chk("t1_start2", qget(st_cyc, 2), t + 9);
    chk("t1_fd", qget(fd_cyc, 0), t + 13);
    chk("t1_nfd", fd_cyc.size(), 1);
    chk("t1_busy_after", int'(busy), 0);

    // 2: empty mask
    do_reset(); clear_logs(); obj_active = 5'b00000;
    cycle(1); t = cyc;
    repeat (4) cycle(0);
    chk("t2_fd", qget(fd_cyc, 0), t + 1);
    chk("t2_nstart", st_cs.size(), 0);
    chk("t2_plot", plot_cnt, 0);

    // 3: done held high
    do_reset(); clear_logs(); resp_mode = 1; obj_active = 5'b10101;
    cycle(1); t = cyc;
    repeat (10) cycle(0);
    chk("t3_nstart", st_cs.size(), 3);
    chk("t3_cs1", qget(st_cs, 1), 2);
    chk("t3_cs2", qget(st_cs, 2), 4);
    chk("t3_start2", qget(st_cyc, 2), t + 5);
    chk("t3_fd", qget(fd_cyc, 0), t + 7);

    // 4: no done at all on index 0
    do_reset(); clear_logs(); resp_mode = 2; obj_active = 5'b00001;
    cycle(1); t = cyc;
    repeat (12) cycle(0);
    chk("t4_fd", qget(fd_cyc, 0), t + 10);
    chk("t4_tmo", int'(timeout_err), 1);
    resp_mode = 0; resp_dly = 2;
    cycle(1);
    repeat (10) cycle(0);
    chk("t4_tmo_sticky", int'(timeout_err), 1);

    // 5: overrun tick in WAIT_DONE, then reset mid-pass
    do_reset(); clear_logs(); resp_mode = 0; resp_dly = 5; obj_active = 5'b00110;
    cycle(1); t = cyc;
    cycle(0); cycle(0);
    obj_active = 5'b11111;
    cycle(1);
    repeat (14) cycle(0);
    chk("t5_nstart", st_cs.size(), 2);
    chk("t5_cs0", qget(st_cs, 0), 1);
    chk("t5_cs1", qget(st_cs, 1), 2);
    chk("t5_fd", qget(fd_cyc, 0), t + 13);
    chk("t5_nfd", fd_cyc.size(), 1);
    chk("t5_ovr", int'(overrun_err), 1);
    chk("t5_tmo", int'(timeout_err), 0);
    clear_logs();
    cycle(1); cycle(0); cycle(0);
    do_reset();
    repeat (3) cycle(0);
    chk("t5_no_fd_after_reset", fd_cyc.size(), 0);

`ifdef DRAW_SEQ_ERASE_EN
    // 6: erase sweep over previous snapshot, then draw
    do_reset(); resp_mode = 0; resp_dly = 2; obj_active = 5'b00011;
    cycle(1);
    repeat (12) cycle(0);
    clear_logs(); obj_active = 5'b00100;
    cycle(1); t = cyc;
    repeat (12) cycle(0);
    chk("t6_nstart", st_cs.size(), 3);
    chk("t6_cs0", qget(st_cs, 0), 0);
    chk("t6_cs1", qget(st_cs, 1), 1);
    chk("t6_cs2", qget(st_cs, 2), 2);
    chk("t6_er0", qget(st_er, 0), 1);
    chk("t6_er1", qget(st_er, 1), 1);
    chk("t6_er2", qget(st_er, 2), 0);
    chk("t6_start2", qget(st_cyc, 2), t + 7);
    chk("t6_fd", qget(fd_cyc, 0), t + 10);
    chk("t6_nfd", fd_cyc.size(), 1);
`endif

    // randomized: ticks, masks, done timing, occasional reset; model compare covers it
    do_reset(); rnd_en = 1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle($urandom_range(0, 24) == 0);
    end
    rnd_en = 0;
    repeat (2) cycle(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
